adjacent_diff: RTL
==================

ADJACENT_DIFF -- requirements
Module: adjacent_diff

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 r_enable  input  1  start pulse; sampled only in IDLE.
REQ-005 init_n  input  11  element count, sampled with r_enable; values above 1024 SHALL be clamped to 1024.
REQ-006 w_enable  output  1  done pulse, high for exactly one cycle.
REQ-007 result  output  64  original value of the last element a[n-1]; 0 when n=0.
REQ-008 arrWEnable_a  output  1  array write strobe.
REQ-009 arrAddr_a  output  10  array address.
REQ-010 arrWData_a  output  64 signed  array write data.
REQ-011 arrRData_a  input  64 signed  array read data, valid the cycle after the address is presented with arrWEnable_a=0.

Function
REQ-012 The block SHALL rewrite the array in place as the inverse of a prefix sum: a'[0]=a[0], a'[i]=a[i]-a[i-1] for 1<=i<n, where each a[i] is the original value.
REQ-013 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-014 IDLE: arrWEnable_a=0; with r_enable=1 and clamped n>0, the FSM SHALL go to READ with i=0, prev=0; with n=0, it SHALL go to DONE.
REQ-015 READ: the block SHALL drive arrAddr_a=i and arrWEnable_a=0, then go to WRITE.
REQ-016 WRITE: the block SHALL drive arrAddr_a=i, arrWEnable_a=1, and arrWData_a=arrRData_a-prev, and SHALL update prev<=arrRData_a and i<=i+1.
REQ-017 After WRITE, the FSM SHALL go to READ when i<n-1 and to DONE when i=n-1.
REQ-018 The block SHALL capture result<=arrRData_a in the WRITE cycle for i=n-1.
REQ-019 DONE: w_enable=1 for one cycle, arrWEnable_a=0, then IDLE.
REQ-020 Latency: w_enable SHALL be high exactly 2n+1 cycles after the r_enable sample edge (1 cycle when n=0).
REQ-021 Subtraction SHALL be 64-bit two's-complement, wrapping modulo 2^64 with no saturation or overflow flag.
REQ-022 In any state other than IDLE, r_enable and init_n SHALL be ignored.
REQ-023 result SHALL hold its value until the next completed run updates it, or reset.
REQ-024 When n=1024, arrAddr_a SHALL reach 1023 with no 10-bit wrap to 0 before DONE.
REQ-025 arrWEnable_a SHALL never be high outside WRITE, and the block SHALL perform exactly one write per element.

Reset
REQ-026 On rst=1 at a clock edge, from any state, the block SHALL enter IDLE with w_enable=0, arrWEnable_a=0, arrAddr_a=0, arrWData_a=0, result=0, i=0, prev=0.
REQ-027 When reset is asserted mid-run, the block SHALL perform no further writes, leaving elements already written as they are, and SHALL not assert w_enable for the aborted run.
REQ-028 rst SHALL take priority over r_enable in the same cycle.

Verification
REQ-029 n=3, array [5,12,10] -> array [5,7,-2], result=10, w_enable 7 cycles after start.
REQ-030 n=0 -> w_enable 1 cycle after start, no writes, result=0.
REQ-031 n=2, array [-2^63, 2^63-1] -> array [-2^63, -1] (wrap), result=2^63-1.
REQ-032 A second r_enable pulse during a run with n=4 -> ignored: a single w_enable at cycle 9 and exactly 4 writes.
REQ-033 rst asserted in the WRITE cycle of i=2 with n=5 -> elements 0-1 rewritten, elements 2-4 unchanged, no w_enable, all outputs 0.
REQ-034 Round trip: n=1000 random signed 32-bit values, prefix-summed by the accumulate stage, then run through this block -> original values restored exactly, result equals the total sum.

Source files
------------

// File: rtl/adjacent_diff.sv
// Adjacent-difference engine: rewrites a[0..n-1] in place as a'[i] = a[i] - a[i-1],
// undoing a prefix sum, through a single-port memory with one-cycle read latency.
module adjacent_diff (
    input  logic               clk,
    input  logic               rst,
    input  logic               r_enable,
    input  logic [10:0]        init_n,
    output logic               w_enable,
    output logic [63:0]        result,
    output logic               arrWEnable_a,
    output logic [9:0]         arrAddr_a,
    output logic signed [63:0] arrWData_a,
    input  logic signed [63:0] arrRData_a
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [10:0]        r_i;
    logic [10:0]        r_n;
    logic [9:0]         r_addr;
    logic signed [63:0] r_prev;
    logic [63:0]        r_result;
    logic               r_w_enable;

    logic [10:0]        w_n_clamped;
    logic               w_last;

    // Clamp the requested count and flag the final element.
    always_comb begin
        w_n_clamped = (init_n > 11'd1024) ? 11'd1024 : init_n;
        w_last      = (r_i == (r_n - 11'd1));
    end

    // Sequencer: READ presents the address, WRITE consumes the returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_i        <= 11'd0;
            r_n        <= 11'd0;
            r_addr     <= 10'd0;
            r_prev     <= 64'sd0;
            r_result   <= 64'd0;
            r_w_enable <= 1'b0;
        end else begin
            r_w_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_enable) begin
                        r_i    <= 11'd0;
                        r_prev <= 64'sd0;
                        r_addr <= 10'd0;
                        if (w_n_clamped == 11'd0) begin
                            r_result   <= 64'd0;
                            r_w_enable <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_n     <= w_n_clamped;
                            r_state <= S_READ;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_prev <= arrRData_a;
                    r_i    <= r_i + 11'd1;
                    // Address is held on the last element so n=1024 never wraps to 0.
                    if (w_last) begin
                        r_result   <= arrRData_a;
                        r_w_enable <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 10'd1;
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write port: data must follow the read word in the same cycle; reset kills the strobe at once.
    always_comb begin
        if ((r_state == S_WRITE) && !rst) begin
            arrWEnable_a = 1'b1;
        end else begin
            arrWEnable_a = 1'b0;
        end
        if (r_state == S_WRITE) begin
            arrWData_a = arrRData_a - r_prev;
        end else begin
            arrWData_a = 64'sd0;
        end
    end

    assign arrAddr_a = r_addr;
    assign result    = r_result;
    assign w_enable  = r_w_enable;

endmodule
